// File: rtl/ifetch_stage_pkg.sv
// Shared widths, tag and metadata layouts for the multi-outstanding I-cache fetch stage.
package ifetch_stage_pkg;

  function automatic int unsigned nw_bits(input int unsigned num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  function automatic int unsigned ps_bits(input int unsigned max_pending);
    return (max_pending > 1) ? $clog2(max_pending) : 1;
  endfunction

  function automatic int unsigned tag_w(input int unsigned uuid_bits,
                                        input int unsigned num_warps,
                                        input int unsigned max_pending);
    return uuid_bits + nw_bits(num_warps) + ps_bits(max_pending);
  endfunction

  localparam int unsigned DEF_NUM_WARPS   = 4;
  localparam int unsigned DEF_NUM_THREADS = 4;
  localparam int unsigned DEF_UUID_BITS   = 16;
  localparam int unsigned DEF_MAX_PENDING = 2;
  localparam int unsigned DEF_NW_BITS     = nw_bits(DEF_NUM_WARPS);
  localparam int unsigned DEF_PS_BITS     = ps_bits(DEF_MAX_PENDING);

  typedef struct packed {
    logic [DEF_UUID_BITS-1:0] uuid;
    logic [DEF_NW_BITS-1:0]   wid;
    logic [DEF_PS_BITS-1:0]   slot;
  } tag_t;

  typedef struct packed {
    logic [31:0]                pc;
    logic [DEF_NUM_THREADS-1:0] tmask;
  } meta_t;

endpackage

// File: rtl/ifetch_rsp_skid_buf.sv
// Two-entry valid/ready buffer: registered output plus one skid entry, full throughput.
module ifetch_rsp_skid_buf #(
  parameter int unsigned DATAW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [DATAW-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [DATAW-1:0] deq_data
);

  logic             skid_valid;
  logic [DATAW-1:0] skid_data;
  logic             push;
  logic             pop;

  assign enq_ready = !(deq_valid && skid_valid);
  assign push      = enq_valid && enq_ready;
  assign pop       = deq_valid && deq_ready;

  // Skid entry is always older than an incoming word, so it moves to the head first.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      deq_valid  <= 1'b0;
      deq_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!deq_valid || pop) begin
      if (skid_valid) begin
        deq_valid  <= 1'b1;
        deq_data   <= skid_data;
        skid_valid <= push;
        if (push) skid_data <= enq_data;
      end else begin
        deq_valid <= push;
        if (push) deq_data <= enq_data;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= enq_data;
    end
  end

endmodule

// File: rtl/icache_fetch_stage_mo.sv
// I-cache fetch stage with several outstanding fetches per warp, out-of-order
// responses matched by slot tag, and per-warp flush of stale responses.
module icache_fetch_stage_mo
  import ifetch_stage_pkg::*;
#(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned UUID_BITS   = 16,
  parameter int unsigned MAX_PENDING = 2,
  parameter int unsigned OUT_REG     = 1,
  localparam int unsigned NW_BITS    = nw_bits(NUM_WARPS),
  localparam int unsigned PS_BITS    = ps_bits(MAX_PENDING),
  localparam int unsigned TAG_W      = tag_w(UUID_BITS, NUM_WARPS, MAX_PENDING)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             ifetch_req_valid,
  output logic                             ifetch_req_ready,
  input  logic [NW_BITS-1:0]               ifetch_req_wid,
  input  logic [31:0]                      ifetch_req_pc,
  input  logic [NUM_THREADS-1:0]           ifetch_req_tmask,
  input  logic [UUID_BITS-1:0]             ifetch_req_uuid,
  output logic                             icache_req_valid,
  input  logic                             icache_req_ready,
  output logic [29:0]                      icache_req_addr,
  output logic [TAG_W-1:0]                 icache_req_tag,
  input  logic                             icache_rsp_valid,
  output logic                             icache_rsp_ready,
  input  logic [31:0]                      icache_rsp_data,
  input  logic [TAG_W-1:0]                 icache_rsp_tag,
  input  logic                             flush_valid,
  input  logic [NW_BITS-1:0]               flush_wid,
  output logic                             ifetch_rsp_valid,
  input  logic                             ifetch_rsp_ready,
  output logic [NW_BITS-1:0]               ifetch_rsp_wid,
  output logic [31:0]                      ifetch_rsp_pc,
  output logic [NUM_THREADS-1:0]           ifetch_rsp_tmask,
  output logic [31:0]                      ifetch_rsp_data,
  output logic [UUID_BITS-1:0]             ifetch_rsp_uuid,
  output logic [NUM_WARPS*(PS_BITS+1)-1:0] pending_cnt_o
);

  localparam int unsigned CNT_W = PS_BITS + 1;
  localparam int unsigned RSP_W = NW_BITS + 32 + NUM_THREADS + 32 + UUID_BITS;

  logic [MAX_PENDING-1:0] alloc_q [NUM_WARPS];
  logic [MAX_PENDING-1:0] alloc_n [NUM_WARPS];
  logic [MAX_PENDING-1:0] stale_q [NUM_WARPS];
  logic [MAX_PENDING-1:0] stale_n [NUM_WARPS];
  logic [CNT_W-1:0]       cnt_q   [NUM_WARPS];
  logic [CNT_W-1:0]       cnt_n   [NUM_WARPS];
  logic [31:0]            pc_q    [NUM_WARPS][MAX_PENDING];
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS][MAX_PENDING];

  logic                   req_fire;
  logic [PS_BITS-1:0]     alloc_slot;
  logic [MAX_PENDING-1:0] free_mask;

  logic [UUID_BITS-1:0]   rsp_uuid;
  logic [NW_BITS-1:0]     rsp_wid;
  logic [PS_BITS-1:0]     rsp_slot;
  logic                   rsp_alloc;
  logic                   rsp_fwd;
  logic                   rsp_fire;
  logic                   rsp_release;

  logic                   enq_valid;
  logic                   enq_ready;
  logic [RSP_W-1:0]       enq_data;
  logic                   deq_valid;
  logic [RSP_W-1:0]       deq_data;

  // Acceptance looks only at registered state; a same-cycle release is not bypassed.
  assign ifetch_req_ready = icache_req_ready
                          && (cnt_q[ifetch_req_wid] < CNT_W'(MAX_PENDING))
                          && !(flush_valid && (flush_wid == ifetch_req_wid));
  assign req_fire         = ifetch_req_valid && ifetch_req_ready;
  assign free_mask        = ~alloc_q[ifetch_req_wid];

  // Lowest free slot of the requesting warp.
  always_comb begin
    alloc_slot = '0;
    for (int s = int'(MAX_PENDING) - 1; s >= 0; s--) begin
      if (free_mask[s]) alloc_slot = PS_BITS'(s);
    end
  end

  assign icache_req_valid = req_fire;
  assign icache_req_addr  = ifetch_req_pc[31:2];
  assign icache_req_tag   = {ifetch_req_uuid, ifetch_req_wid, alloc_slot};

  assign rsp_uuid  = icache_rsp_tag[TAG_W-1 -: UUID_BITS];
  assign rsp_wid   = icache_rsp_tag[PS_BITS +: NW_BITS];
  assign rsp_slot  = icache_rsp_tag[PS_BITS-1:0];
  assign rsp_alloc = alloc_q[rsp_wid][rsp_slot];
  assign rsp_fwd   = rsp_alloc && !stale_q[rsp_wid][rsp_slot]
                   && !(flush_valid && (flush_wid == rsp_wid));

  // Responses that will not be forwarded are always consumed.
  assign enq_valid        = icache_rsp_valid && rsp_fwd;
  assign icache_rsp_ready = !rsp_fwd || enq_ready;
  assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;
  assign rsp_release      = rsp_fire && rsp_alloc;
  assign enq_data         = {rsp_wid, pc_q[rsp_wid][rsp_slot], tmask_q[rsp_wid][rsp_slot],
                             icache_rsp_data, rsp_uuid};

  // Slot bookkeeping: flush marks, then release, then allocate.
  always_comb begin
    for (int w = 0; w < int'(NUM_WARPS); w++) begin
      alloc_n[w] = alloc_q[w];
      stale_n[w] = stale_q[w];
      cnt_n[w]   = cnt_q[w];
    end
    if (flush_valid) begin
      stale_n[flush_wid] = stale_q[flush_wid] | alloc_q[flush_wid];
    end
    if (rsp_release) begin
      alloc_n[rsp_wid][rsp_slot] = 1'b0;
      cnt_n[rsp_wid]             = cnt_n[rsp_wid] - CNT_W'(1);
    end
    if (req_fire) begin
      alloc_n[ifetch_req_wid][alloc_slot] = 1'b1;
      stale_n[ifetch_req_wid][alloc_slot] = 1'b0;
      cnt_n[ifetch_req_wid]               = cnt_n[ifetch_req_wid] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
        alloc_q[w] <= '0;
        stale_q[w] <= '0;
        cnt_q[w]   <= '0;
        for (int s = 0; s < int'(MAX_PENDING); s++) begin
          pc_q[w][s]    <= '0;
          tmask_q[w][s] <= '0;
        end
      end
    end else begin
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
        alloc_q[w] <= alloc_n[w];
        stale_q[w] <= stale_n[w];
        cnt_q[w]   <= cnt_n[w];
      end
      if (req_fire) begin
        pc_q[ifetch_req_wid][alloc_slot]    <= ifetch_req_pc;
        tmask_q[ifetch_req_wid][alloc_slot] <= ifetch_req_tmask;
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      a_stray_tag: assert (!(icache_rsp_valid && !rsp_alloc))
        else $warning("icache response tag to unallocated slot dropped");
      a_cnt_underflow: assert (!(rsp_release && (cnt_q[rsp_wid] == '0)))
        else $error("pending count underflow");
      a_cnt_overflow: assert (!(req_fire && (cnt_q[ifetch_req_wid] >= CNT_W'(MAX_PENDING))))
        else $error("pending count overflow");
    end
  end

  for (genvar g = 0; g < int'(NUM_WARPS); g++) begin : g_cnt
    assign pending_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  if (OUT_REG != 0) begin : g_skid
    ifetch_rsp_skid_buf #(.DATAW(RSP_W)) u_skid (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .enq_valid (enq_valid),
      .enq_ready (enq_ready),
      .enq_data  (enq_data),
      .deq_valid (deq_valid),
      .deq_ready (ifetch_rsp_ready),
      .deq_data  (deq_data)
    );
  end else begin : g_bypass
    assign deq_valid = enq_valid;
    assign enq_ready = ifetch_rsp_ready;
    assign deq_data  = enq_data;
  end

  assign ifetch_rsp_valid = deq_valid;
  assign {ifetch_rsp_wid, ifetch_rsp_pc, ifetch_rsp_tmask, ifetch_rsp_data, ifetch_rsp_uuid} = deq_data;

endmodule

// File: tb/tb_icache_fetch_stage_mo.sv
// Randomized and directed bench for icache_fetch_stage_mo with an in-flight list model and scoreboard.
module tb_icache_fetch_stage_mo;
  import ifetch_stage_pkg::*;

  localparam int NW  = 4;
  localparam int NT  = 4;
  localparam int UB  = 16;
  localparam int MP  = 2;
  localparam int NWB = 2;
  localparam int PSB = 1;
  localparam int TW  = UB + NWB + PSB;

  logic              clk_i;
  logic              rst_ni;
  logic              ifetch_req_valid;
  logic              ifetch_req_ready;
  logic [NWB-1:0]    ifetch_req_wid;
  logic [31:0]       ifetch_req_pc;
  logic [NT-1:0]     ifetch_req_tmask;
  logic [UB-1:0]     ifetch_req_uuid;
  logic              icache_req_valid;
  logic              icache_req_ready;
  logic [29:0]       icache_req_addr;
  logic [TW-1:0]     icache_req_tag;
  logic              icache_rsp_valid;
  logic              icache_rsp_ready;
  logic [31:0]       icache_rsp_data;
  logic [TW-1:0]     icache_rsp_tag;
  logic              flush_valid;
  logic [NWB-1:0]    flush_wid;
  logic              ifetch_rsp_valid;
  logic              ifetch_rsp_ready;
  logic [NWB-1:0]    ifetch_rsp_wid;
  logic [31:0]       ifetch_rsp_pc;
  logic [NT-1:0]     ifetch_rsp_tmask;
  logic [31:0]       ifetch_rsp_data;
  logic [UB-1:0]     ifetch_rsp_uuid;
  logic [NW*(PSB+1)-1:0] pending_cnt_o;

  icache_fetch_stage_mo #(
    .NUM_WARPS(NW), .NUM_THREADS(NT), .UUID_BITS(UB), .MAX_PENDING(MP), .OUT_REG(1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ifetch_req_valid(ifetch_req_valid), .ifetch_req_ready(ifetch_req_ready),
    .ifetch_req_wid(ifetch_req_wid), .ifetch_req_pc(ifetch_req_pc),
    .ifetch_req_tmask(ifetch_req_tmask), .ifetch_req_uuid(ifetch_req_uuid),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .flush_valid(flush_valid), .flush_wid(flush_wid),
    .ifetch_rsp_valid(ifetch_rsp_valid), .ifetch_rsp_ready(ifetch_rsp_ready),
    .ifetch_rsp_wid(ifetch_rsp_wid), .ifetch_rsp_pc(ifetch_rsp_pc),
    .ifetch_rsp_tmask(ifetch_rsp_tmask), .ifetch_rsp_data(ifetch_rsp_data),
    .ifetch_rsp_uuid(ifetch_rsp_uuid), .pending_cnt_o(pending_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int          wid;
    int          slot;
    logic [31:0] pc;
    logic [3:0]  tmask;
    logic [15:0] uuid;
    bit          stale;
  } fl_t;

  typedef struct {
    logic [1:0]  wid;
    logic [31:0] pc;
    logic [3:0]  tmask;
    logic [31:0] data;
    logic [15:0] uuid;
  } exp_t;

  fl_t  fl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rsp_fired;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int w);
    int c = 0;
    foreach (fl[i]) if (fl[i].wid == w) c++;
    return c;
  endfunction

  function automatic int find(input int w, input int s);
    foreach (fl[i]) if (fl[i].wid == w && fl[i].slot == s) return i;
    return -1;
  endfunction

  function automatic int lowest_free(input int w);
    for (int s = 0; s < MP; s++) if (find(w, s) < 0) return s;
    return -1;
  endfunction

  function automatic logic [15:0] uuid_of(input int w, input int s);
    int i = find(w, s);
    return (i >= 0) ? fl[i].uuid : 16'h0;
  endfunction

  task automatic idle_inputs();
    ifetch_req_valid = 1'b0;
    icache_rsp_valid = 1'b0;
    flush_valid      = 1'b0;
  endtask

  // Predict and check this cycle's handshakes, then update the model across the edge.
  task automatic step();
    tag_t tg;
    int   idx;
    int   w;
    int   s;
    bit   rdy_req;
    bit   rdy_rsp;
    bit   fwd;
    #3;
    if (!rst_ni) begin
      @(posedge clk_i);
      #1;
      fl.delete();
      sb.delete();
      idle_inputs();
      return;
    end
    for (int i = 0; i < NW; i++)
      check("pending_cnt", 64'(pending_cnt_o[i*2 +: 2]), 64'(cnt_of(i)));
    rsp_fired = 1'b0;
    rdy_req   = 1'b0;
    idx       = -1;
    fwd       = 1'b0;
    w         = int'(ifetch_req_wid);
    s         = 0;
    if (ifetch_req_valid) begin
      rdy_req = icache_req_ready && (cnt_of(w) < MP) && !(flush_valid && flush_wid == ifetch_req_wid);
      check("req_ready", 64'(ifetch_req_ready), 64'(rdy_req));
      check("icache_req_valid", 64'(icache_req_valid), 64'(rdy_req));
      if (rdy_req) begin
        s = lowest_free(w);
        check("req_tag", 64'(icache_req_tag), 64'({ifetch_req_uuid, ifetch_req_wid, 1'(s)}));
        check("req_addr", 64'(icache_req_addr), 64'(ifetch_req_pc >> 2));
      end
    end
    if (icache_rsp_valid) begin
      tg  = tag_t'(icache_rsp_tag);
      idx = find(int'(tg.wid), int'(tg.slot));
      fwd = (idx >= 0) && !fl[idx].stale && !(flush_valid && flush_wid == tg.wid);
      rdy_rsp = !fwd || (sb.size() < 2);
      check("icache_rsp_ready", 64'(icache_rsp_ready), 64'(rdy_rsp));
      if (rdy_rsp) begin
        rsp_fired = 1'b1;
        if (fwd) sb.push_back('{wid: tg.wid, pc: fl[idx].pc, tmask: fl[idx].tmask,
                                data: icache_rsp_data, uuid: tg.uuid});
      end
    end
    if (flush_valid) foreach (fl[i]) if (fl[i].wid == int'(flush_wid)) fl[i].stale = 1'b1;
    if (rsp_fired && idx >= 0) fl.delete(idx);
    if (rdy_req) fl.push_back('{wid: w, slot: s, pc: ifetch_req_pc, tmask: ifetch_req_tmask,
                                uuid: ifetch_req_uuid, stale: 1'b0});
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic issue(input int w, input logic [31:0] pc, input logic [3:0] tm, input logic [15:0] u);
    ifetch_req_valid = 1'b1;
    ifetch_req_wid   = 2'(w);
    ifetch_req_pc    = pc;
    ifetch_req_tmask = tm;
    ifetch_req_uuid  = u;
    step();
  endtask

  task automatic set_rsp(input int w, input int s, input logic [31:0] d);
    tag_t t;
    t.uuid = uuid_of(w, s);
    t.wid  = 2'(w);
    t.slot = 1'(s);
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = t;
    icache_rsp_data  = d;
  endtask

  task automatic send_rsp(input int w, input int s, input logic [31:0] d);
    bit done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      set_rsp(w, s, d);
      step();
      if (rsp_fired) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: got no accept expected accept within 40 cycles (w%0d s%0d)", w, s);
    end
  endtask

  // Scoreboard monitor: every delivered response must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && ifetch_rsp_valid && ifetch_rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got pc 0x%0h data 0x%0h expected no response", ifetch_rsp_pc, ifetch_rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp_wid", 64'(ifetch_rsp_wid), 64'(e.wid));
          check("rsp_pc", 64'(ifetch_rsp_pc), 64'(e.pc));
          check("rsp_tmask", 64'(ifetch_rsp_tmask), 64'(e.tmask));
          check("rsp_data", 64'(ifetch_rsp_data), 64'(e.data));
          check("rsp_uuid", 64'(ifetch_rsp_uuid), 64'(e.uuid));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws[4];
    int ss[4];
    int k;
    logic [31:0] r;
    rst_ni           = 1'b0;
    ifetch_req_wid   = '0;
    ifetch_req_pc    = '0;
    ifetch_req_tmask = '0;
    ifetch_req_uuid  = '0;
    icache_rsp_tag   = '0;
    icache_rsp_data  = '0;
    flush_wid        = '0;
    icache_req_ready = 1'b1;
    ifetch_rsp_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check("reset_rsp_valid", 64'(ifetch_rsp_valid), 64'(0));
    check("reset_rsp_data", 64'(ifetch_rsp_data), 64'(0));
    check("reset_rsp_pc", 64'(ifetch_rsp_pc), 64'(0));
    check("reset_pending", 64'(pending_cnt_o), 64'(0));

    // Two fetches on warp0 held by the cache, third must stall.
    issue(0, 32'h100, 4'hF, 16'h0011);
    issue(0, 32'h104, 4'h3, 16'h0012);
    issue(0, 32'h108, 4'h1, 16'h0013);
    check("t1_cnt", 64'(pending_cnt_o[1:0]), 64'(2));

    // Out-of-order return.
    send_rsp(0, 1, 32'hA);
    send_rsp(0, 0, 32'hB);
    repeat (3) step();
    check("t2_drained", 64'(sb.size()), 64'(0));
    check("t2_cnt", 64'(pending_cnt_o[1:0]), 64'(0));

    // Flush warp2 with two in flight; both responses are dropped.
    issue(2, 32'h200, 4'h5, 16'h0021);
    issue(2, 32'h204, 4'h6, 16'h0022);
    flush_valid = 1'b1;
    flush_wid   = 2'd2;
    step();
    send_rsp(2, 0, 32'hC0);
    send_rsp(2, 1, 32'hC1);
    check("t3_no_rsp", 64'(ifetch_rsp_valid), 64'(0));
    issue(2, 32'h300, 4'h7, 16'h0023);
    send_rsp(2, 0, 32'hC2);
    repeat (2) step();

    // Downstream stalled while responses stream in: exactly two buffered.
    issue(1, 32'h400, 4'h1, 16'h0031);
    issue(1, 32'h404, 4'h2, 16'h0032);
    issue(3, 32'h408, 4'h4, 16'h0033);
    issue(3, 32'h40C, 4'h8, 16'h0034);
    ws = '{1, 1, 3, 3};
    ss = '{0, 1, 0, 1};
    k  = 0;
    ifetch_rsp_ready = 1'b0;
    repeat (5) begin
      if (k < 4) set_rsp(ws[k], ss[k], 32'hD0 + 32'(k));
      step();
      if (rsp_fired) k++;
    end
    check("t4_buffered", 64'(k), 64'(2));
    check("t4_rsp_valid", 64'(ifetch_rsp_valid), 64'(1));
    ifetch_rsp_ready = 1'b1;
    send_rsp(3, 0, 32'hD2);
    send_rsp(3, 1, 32'hD3);
    repeat (3) step();

    // Full warp1: simultaneous request and release; freed slot usable next cycle.
    issue(1, 32'h500, 4'h1, 16'h0041);
    issue(1, 32'h504, 4'h2, 16'h0042);
    ifetch_req_valid = 1'b1;
    ifetch_req_wid   = 2'd1;
    ifetch_req_pc    = 32'h508;
    ifetch_req_tmask = 4'h3;
    ifetch_req_uuid  = 16'h0043;
    set_rsp(1, 0, 32'hE0);
    step();
    issue(1, 32'h508, 4'h3, 16'h0043);
    check("t5_cnt", 64'(pending_cnt_o[3:2]), 64'(2));
    send_rsp(1, 1, 32'hE1);
    send_rsp(1, 0, 32'hE2);
    repeat (3) step();

    // Reset mid-traffic, then a stray response to a pre-reset tag.
    issue(0, 32'h600, 4'h9, 16'h0051);
    issue(3, 32'h700, 4'hA, 16'h0052);
    set_rsp(0, 0, 32'hF0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check("t6_rsp_valid", 64'(ifetch_rsp_valid), 64'(0));
    check("t6_rsp_data", 64'(ifetch_rsp_data), 64'(0));
    check("t6_pending", 64'(pending_cnt_o), 64'(0));
    send_rsp(0, 0, 32'hDEAD);
    repeat (2) step();
    check("t6_no_rsp", 64'(ifetch_rsp_valid), 64'(0));

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      icache_req_ready = ($urandom_range(0, 3) != 0);
      ifetch_rsp_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6) begin
        r = $urandom;
        r[1:0] = 2'b00;
        ifetch_req_valid = 1'b1;
        ifetch_req_wid   = 2'($urandom_range(0, NW - 1));
        ifetch_req_pc    = r;
        ifetch_req_tmask = 4'($urandom);
        ifetch_req_uuid  = 16'($urandom);
      end
      if (fl.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, fl.size() - 1);
        set_rsp(fl[k].wid, fl[k].slot, $urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        flush_valid = 1'b1;
        flush_wid   = 2'($urandom_range(0, NW - 1));
      end
      step();
    end

    // Drain everything still in flight.
    icache_req_ready = 1'b1;
    ifetch_rsp_ready = 1'b1;
    for (int g = 0; g < 64 && fl.size() > 0; g++) send_rsp(fl[0].wid, fl[0].slot, $urandom);
    repeat (4) step();
    check("final_drained", 64'(sb.size()), 64'(0));
    check("final_pending", 64'(pending_cnt_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
